// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one non-pipelined memory port between instruction
// fetch (I) and load/store (D). One transaction in flight at a time; D has
// priority. The winner's request is registered onto mem_* and held until
// mem_ready, and the response is routed back combinationally.
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// D grants made while I waits, the next arbitration with i_valid=1 grants I.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_valid,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state_reg;
  logic              mem_valid_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [STRB_W-1:0] mem_wstrb_reg;

  logic grant_i;
  logic grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;

  // Arbitration: D first, unless I has waited through LIMIT D grants.
  always_comb begin
    grant_i = (state_reg == IDLE) && i_valid &&
              (!d_valid || (starve_cnt_reg == LIMIT));
    grant_d = (state_reg == IDLE) && d_valid && !grant_i;
  end

  // Count D grants that bypass a waiting fetch; saturate at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (grant_i) begin
      starve_cnt_reg <= '0;
    end else if (grant_d) begin
      if (!i_valid) begin
        starve_cnt_reg <= '0;
      end else if (starve_cnt_reg != LIMIT) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end
`else
  // Arbitration: strict D priority.
  always_comb begin
    grant_d = (state_reg == IDLE) && d_valid;
    grant_i = (state_reg == IDLE) && i_valid && !d_valid;
  end
`endif

  // FSM and registered memory request; mem_* held stable until mem_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_valid_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg     <= BUSY_D;
            mem_valid_reg <= 1'b1;
            mem_we_reg    <= d_we;
            mem_addr_reg  <= d_addr;
            mem_wdata_reg <= d_wdata;
            mem_wstrb_reg <= d_wstrb;
          end else if (grant_i) begin
            // Fetches are always reads with no byte enables.
            state_reg     <= BUSY_I;
            mem_valid_reg <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= i_addr;
            mem_wstrb_reg <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            state_reg     <= IDLE;
            mem_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          mem_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Response routing: ready only in the owner's BUSY state, same cycle as ack.
  always_comb begin
    i_ready = (state_reg == BUSY_I) && mem_ready;
    d_ready = (state_reg == BUSY_D) && mem_ready;
  end

  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_valid = mem_valid_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign busy      = (state_reg != IDLE);

endmodule
